// File: rtl/bram_stream_ctrl.sv
// bram_stream_ctrl: reads a block of words from BRAM port B and streams them
// to an AXI-Stream slave as one packet terminated by tlast. A rising edge on
// the start GPIO launches each transfer. Reads go into a 2-entry output FIFO
// and are issued only when a FIFO slot is free, which gives 1 beat per clock
// under continuous tready.
`timescale 1ns/1ps

module bram_stream_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_gpio,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  xfer_len,
    output logic              BRAM_PORTB_en,
    output logic [3:0]        BRAM_PORTB_we,
    output logic [ADDR_W-1:0] BRAM_PORTB_addr,
    output logic [DATA_W-1:0] BRAM_PORTB_din,
    input  logic [DATA_W-1:0] BRAM_PORTB_dout,
    output logic [DATA_W-1:0] S_AXIS_tdata,
    output logic [3:0]        S_AXIS_tkeep,
    output logic              S_AXIS_tvalid,
    output logic              S_AXIS_tlast,
    input  logic              S_AXIS_tready,
    output logic              busy,
    output logic              done,
    output logic              start_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Controller state
    state_t              state_q,         state_d;
    logic                start_q,         start_d;
    logic [ADDR_W-1:0]   addr_q,          addr_d;
    logic [LEN_W-1:0]    reads_left_q,    reads_left_d;

    // One read may be in flight (address presented, data arrives next cycle)
    logic                inflight_q,      inflight_d;
    logic                inflight_last_q, inflight_last_d;

    // Two-entry FIFO kept as head/tail registers; head drives the stream
    logic [1:0]          count_q,         count_d;
    logic [DATA_W-1:0]   head_q,          head_d;
    logic [DATA_W-1:0]   tail_q,          tail_d;
    logic                head_last_q,     head_last_d;
    logic                tail_last_q,     tail_last_d;

    // Registered status outputs
    logic                tvalid_q,        tvalid_d;
    logic                busy_q,          busy_d;
    logic                done_q,          done_d;
    logic                start_err_q,     start_err_d;

    // Combinational helpers
    logic                req_s;
    logic                pop_s;
    logic                push_s;
    logic [2:0]          occ_s;
    logic                en_s;
    logic                last_issue_s;

    // Next-state computation: edge detect, read issue, FIFO and FSM
    always_comb begin
        state_d         = state_q;
        start_d         = start_gpio;
        addr_d          = addr_q;
        reads_left_d    = reads_left_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        count_d         = count_q;
        head_d          = head_q;
        tail_d          = tail_q;
        head_last_d     = head_last_q;
        tail_last_d     = tail_last_q;
        done_d          = 1'b0;
        start_err_d     = start_err_q;

        req_s  = start_gpio & ~start_q;
        pop_s  = tvalid_q & S_AXIS_tready;
        push_s = inflight_q;

        // Slots that will be committed after this cycle; a read may be issued
        // only if it still fits once its data lands.
        occ_s = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        if (state_q == ST_RUN) begin
            en_s = (occ_s < 3'd2);
        end else begin
            en_s = 1'b0;
        end
        if (en_s && (reads_left_q == {{(LEN_W-1){1'b0}}, 1'b1})) begin
            last_issue_s = 1'b1;
        end else begin
            last_issue_s = 1'b0;
        end

        inflight_d      = en_s;
        inflight_last_d = last_issue_s;

        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    start_err_d  = 1'b0;
                    addr_d       = base_addr;
                    reads_left_d = xfer_len;
                    if (xfer_len == {LEN_W{1'b0}}) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (req_s) begin
                    start_err_d = 1'b1;
                end else begin
                    start_err_d = start_err_q;
                end
                if (en_s) begin
                    addr_d       = addr_q + ADDR_W'(ADDR_STEP);
                    reads_left_d = reads_left_q - {{(LEN_W-1){1'b0}}, 1'b1};
                    if (last_issue_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (req_s) begin
                    start_err_d = 1'b1;
                end else begin
                    start_err_d = start_err_q;
                end
                if (pop_s && head_last_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (count_q)
            2'd0: begin
                if (push_s) begin
                    head_d      = BRAM_PORTB_dout;
                    head_last_d = inflight_last_q;
                    count_d     = 2'd1;
                end else begin
                    count_d = 2'd0;
                end
            end
            2'd1: begin
                if (push_s && pop_s) begin
                    head_d      = BRAM_PORTB_dout;
                    head_last_d = inflight_last_q;
                    count_d     = 2'd1;
                end else if (pop_s) begin
                    head_last_d = 1'b0;
                    count_d     = 2'd0;
                end else if (push_s) begin
                    tail_d      = BRAM_PORTB_dout;
                    tail_last_d = inflight_last_q;
                    count_d     = 2'd2;
                end else begin
                    count_d = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    head_d      = tail_q;
                    head_last_d = tail_last_q;
                    if (push_s) begin
                        tail_d      = BRAM_PORTB_dout;
                        tail_last_d = inflight_last_q;
                        count_d     = 2'd2;
                    end else begin
                        count_d = 2'd1;
                    end
                end else begin
                    count_d = 2'd2;
                end
            end
            default: begin
                count_d     = 2'd0;
                head_last_d = 1'b0;
            end
        endcase

        tvalid_d = (count_d != 2'd0);
        busy_d   = (state_d != ST_IDLE);
    end

    // State and output registers; reset returns to an idle, empty controller
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            start_q         <= 1'b0;
            addr_q          <= {ADDR_W{1'b0}};
            reads_left_q    <= {LEN_W{1'b0}};
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= 2'd0;
            head_q          <= {DATA_W{1'b0}};
            tail_q          <= {DATA_W{1'b0}};
            head_last_q     <= 1'b0;
            tail_last_q     <= 1'b0;
            tvalid_q        <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            start_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            start_q         <= start_d;
            addr_q          <= addr_d;
            reads_left_q    <= reads_left_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            count_q         <= count_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            head_last_q     <= head_last_d;
            tail_last_q     <= tail_last_d;
            tvalid_q        <= tvalid_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            start_err_q     <= start_err_d;
        end
    end

    // Read enable depends on this cycle's pop so the pipeline can run at full rate
    assign BRAM_PORTB_en   = en_s;
    assign BRAM_PORTB_we   = 4'h0;
    assign BRAM_PORTB_addr = addr_q;
    assign BRAM_PORTB_din  = {DATA_W{1'b0}};

    assign S_AXIS_tdata  = head_q;
    assign S_AXIS_tkeep  = 4'hF;
    assign S_AXIS_tvalid = tvalid_q;
    assign S_AXIS_tlast  = head_last_q;

    assign busy      = busy_q;
    assign done      = done_q;
    assign start_err = start_err_q;

endmodule

// File: tb/tb_bram_stream_ctrl.sv
// Testbench for bram_stream_ctrl: BRAM model, tready driver, scoreboard
// queues filled by the stimulus and a negedge monitor that checks every
// read address and every stream beat.
`timescale 1ns/1ps

module tb_bram_stream_ctrl;

    logic        clk;
    logic        rst;
    logic        start_gpio;
    logic [31:0] base_addr;
    logic [15:0] xfer_len;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic        busy;
    logic        done;
    logic        start_err;

    logic [31:0] mem [0:511];
    logic [31:0] exp_addr_q [$];
    logic [32:0] exp_beat_q [$];

    int checks = 0;
    int errors = 0;
    int tready_mode = 0;
    int beats_seen = 0;
    bit zlen_ok = 1'b0;

    bram_stream_ctrl #(
        .ADDR_W(32), .DATA_W(32), .LEN_W(16), .ADDR_STEP(4)
    ) dut (
        .clk(clk), .rst(rst), .start_gpio(start_gpio),
        .base_addr(base_addr), .xfer_len(xfer_len),
        .BRAM_PORTB_en(en), .BRAM_PORTB_we(we), .BRAM_PORTB_addr(addr),
        .BRAM_PORTB_din(din), .BRAM_PORTB_dout(dout),
        .S_AXIS_tdata(tdata), .S_AXIS_tkeep(tkeep), .S_AXIS_tvalid(tvalid),
        .S_AXIS_tlast(tlast), .S_AXIS_tready(tready),
        .busy(busy), .done(done), .start_err(start_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // BRAM port B model: one-cycle read latency
    initial begin
        dout = 32'h0;
        forever begin
            @(posedge clk);
            if (!rst && en) dout <= mem[addr[10:2]];
        end
    end

    // tready driver: mode 0 = always ready, mode 1 = alternate 1,0,1,0
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tready_mode == 0) tready = 1'b1;
            else tready = ~tready;
        end
    end

    // Monitor: compares addresses, beats, holding behaviour and done timing
    initial begin
        logic        last_hs_prev;
        logic        hold_v;
        logic [31:0] hold_d;
        logic        hold_l;
        logic [31:0] ea;
        logic [32:0] eb;
        last_hs_prev = 1'b0;
        hold_v = 1'b0;
        hold_d = 32'h0;
        hold_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_hs_prev = 1'b0;
                hold_v = 1'b0;
            end else begin
                if (last_hs_prev) chk("done_after_tlast", {31'h0, done}, 32'h1);
                else if (!zlen_ok) chk("no_spurious_done", {31'h0, done}, 32'h0);
                if (en) begin
                    if (exp_addr_q.size() == 0) begin
                        fail_now("unexpected_en");
                    end else begin
                        ea = exp_addr_q.pop_front();
                        chk("bram_addr", addr, ea);
                        chk("bram_we", {28'h0, we}, 32'h0);
                    end
                end
                if (hold_v) begin
                    chk("tvalid_held", {31'h0, tvalid}, 32'h1);
                    chk("tdata_held", tdata, hold_d);
                    chk("tlast_held", {31'h0, tlast}, {31'h0, hold_l});
                end
                if (tvalid && tready) begin
                    if (exp_beat_q.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        eb = exp_beat_q.pop_front();
                        chk("beat_data", tdata, eb[31:0]);
                        chk("beat_last", {31'h0, tlast}, {31'h0, eb[32]});
                    end
                    beats_seen++;
                end
                last_hs_prev = tvalid & tready & tlast;
                hold_v = tvalid & ~tready;
                hold_d = tdata;
                hold_l = tlast;
            end
        end
    end

    // Queue the expected addresses and beats for one accepted transfer
    task automatic push_expect(input logic [31:0] base, input logic [15:0] len);
        logic [31:0] a;
        logic        lb;
        for (int i = 0; i < int'(len); i++) begin
            a  = base + 32'(i * 4);
            lb = (i == int'(len) - 1);
            exp_addr_q.push_back(a);
            exp_beat_q.push_back({lb, mem[a[10:2]]});
        end
    endtask

    // One transfer with optional second start edge at negedge inject_n
    task automatic run_xfer(input logic [31:0] base, input logic [15:0] len,
                            input int exp_n, input int inject_n);
        int n;
        bit got;
        @(posedge clk);
        #1;
        base_addr  = base;
        xfer_len   = len;
        start_gpio = 1'b1;
        push_expect(base, len);
        n = 0;
        got = 1'b0;
        while (!got && n < 500) begin
            @(negedge clk);
            n++;
            if (n == 2) start_gpio = 1'b0;
            if (n == 3) chk("busy_high", {31'h0, busy}, 32'h1);
            if (inject_n != 0 && n == inject_n) begin
                start_gpio = 1'b1;
                base_addr  = 32'hDEAD_0000;
                xfer_len   = 16'd3;
            end
            if (inject_n != 0 && n == inject_n + 1) start_gpio = 1'b0;
            if (inject_n != 0 && n == inject_n + 3) chk("start_err_set", {31'h0, start_err}, 32'h1);
            if (done) got = 1'b1;
        end
        if (!got) begin
            fail_now("done_timeout");
        end else begin
            if (exp_n != 0) chk("done_latency", 32'(n), 32'(exp_n));
            chk("busy_low_at_done", {31'h0, busy}, 32'h0);
        end
        chk("beats_left", 32'(exp_beat_q.size()), 32'h0);
        chk("addrs_left", 32'(exp_addr_q.size()), 32'h0);
    endtask

    initial begin
        int snap;
        int w;
        for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[0] = 32'h0000_0011;
        mem[1] = 32'h0000_0022;
        mem[2] = 32'h0000_0033;
        mem[3] = 32'h0000_0044;
        rst        = 1'b1;
        start_gpio = 1'b0;
        base_addr  = 32'h0;
        xfer_len   = 16'h0;
        #1;
        chk("rst_tvalid", {31'h0, tvalid}, 32'h0);
        chk("rst_en", {31'h0, en}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_tkeep", {28'h0, tkeep}, 32'hF);
        chk("rst_din", din, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: four words from 0, full rate, done 1 cycle after tlast
        run_xfer(32'h0000_0000, 16'd4, 8, 0);

        // 2: eight words with tready toggling
        tready_mode = 1;
        run_xfer(32'h0000_0040, 16'd8, 0, 0);
        tready_mode = 0;
        repeat (2) @(posedge clk);

        // 4: second start edge during a 16-word transfer
        run_xfer(32'h0000_0080, 16'd16, 20, 6);
        chk("start_err_sticky", {31'h0, start_err}, 32'h1);

        // 3: zero-length start clears start_err, pulses done, no reads
        @(posedge clk);
        #1;
        zlen_ok    = 1'b1;
        base_addr  = 32'h0000_0200;
        xfer_len   = 16'd0;
        start_gpio = 1'b1;
        @(negedge clk);
        chk("zlen_done_early", {31'h0, done}, 32'h0);
        @(negedge clk);
        start_gpio = 1'b0;
        chk("zlen_done", {31'h0, done}, 32'h1);
        chk("zlen_busy", {31'h0, busy}, 32'h0);
        chk("zlen_clears_err", {31'h0, start_err}, 32'h0);
        @(negedge clk);
        chk("zlen_done_pulse", {31'h0, done}, 32'h0);
        chk("zlen_busy_after", {31'h0, busy}, 32'h0);
        chk("zlen_no_tvalid", {31'h0, tvalid}, 32'h0);
        zlen_ok = 1'b0;

        // 5: reset after two beats of a six-word transfer
        @(posedge clk);
        #1;
        base_addr  = 32'h0000_0020;
        xfer_len   = 16'd6;
        start_gpio = 1'b1;
        push_expect(32'h0000_0020, 16'd6);
        snap = beats_seen;
        w = 0;
        while (beats_seen < snap + 2 && w < 100) begin
            @(negedge clk);
            w++;
            if (w == 2) start_gpio = 1'b0;
        end
        if (beats_seen < snap + 2) fail_now("reset_test_timeout");
        start_gpio = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_tvalid", {31'h0, tvalid}, 32'h0);
        chk("mid_rst_en", {31'h0, en}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        exp_addr_q.delete();
        exp_beat_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_xfer(32'h0000_0100, 16'd1, 5, 0);

        // 6: address wrap at the top of the address space
        run_xfer(32'hFFFF_FFF8, 16'd3, 7, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

endmodule
